mem_arbiter: RTL and testbench

Two-port memory arbiter that shares the single 8-bit external memory port between the `mips` core and a DMA/loader requester. It captures one request at a time and drives the memory strobes for exactly one cycle. It then waits a fixed memory latency and returns the read data, with a done pulse, to the requester that was served. It sits between `mips` (`memread`/`memwrite`/`adr`/`writedata`/`memdata`, plus the core's stall logic) and the memory model/RAM.

---
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one memory port between a CPU and a DMA requester: one strobe cycle, fixed read latency, done pulse.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the CPU has fixed priority.
module mem_arbiter #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_adr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic             cpu_gnt,
    output logic             cpu_done,
    output logic [WIDTH-1:0] cpu_rdata,
    input  logic             dma_req,
    input  logic             dma_we,
    input  logic [WIDTH-1:0] dma_adr,
    input  logic [WIDTH-1:0] dma_wdata,
    output logic             dma_gnt,
    output logic             dma_done,
    output logic [WIDTH-1:0] dma_rdata,
    output logic [WIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_read,
    output logic             mem_write,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [1:0]       dbg_state
);

    // Handshake: *_req stays high until *_gnt; a request is committed once sampled in IDLE/DONE,
    // *_gnt pulses in its strobe cycle and *_done pulses in the cycle its rdata becomes valid.
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

    localparam logic [1:0] CNT_LOAD = 2'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("mem_arbiter: LATENCY must be in 1..4");
    end

    state_t           state, state_next;
    logic [1:0]       cnt, cnt_next;
    logic             cap_we;
    logic             cap_id;
    logic             take;
    logic             pick_dma;
    logic             win_we;
    logic [WIDTH-1:0] win_adr;
    logic [WIDTH-1:0] win_wdata;
    logic             prefer_dma;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_dma;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_dma <= 1'b1;
        end else if (state == ISSUE) begin
            last_dma <= cap_id;
        end
    end

    assign prefer_dma = !last_dma;
`else
    assign prefer_dma = 1'b0;
`endif

    always_comb begin
        take       = ((state == IDLE) || (state == DONE)) && (cpu_req || dma_req);
        pick_dma   = dma_req && (!cpu_req || prefer_dma);
        win_we     = pick_dma ? dma_we    : cpu_we;
        win_adr    = pick_dma ? dma_adr   : cpu_adr;
        win_wdata  = pick_dma ? dma_wdata : cpu_wdata;
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE, DONE: state_next = take ? ISSUE : IDLE;
            ISSUE: begin
                cnt_next   = CNT_LOAD;
                state_next = (CNT_LOAD != 2'd0) ? WAIT : DONE;
            end
            WAIT: begin
                cnt_next   = cnt - 2'd1;
                state_next = (cnt == 2'd1) ? DONE : WAIT;
            end
            default: state_next = IDLE;
        endcase
    end

    // Memory strobes and grants are loaded on the capture edge so they are flops during ISSUE.
    // Read data is sampled on the edge entering DONE so rdata is valid together with done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            cap_we    <= 1'b0;
            cap_id    <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_adr   <= '0;
            mem_wdata <= '0;
            cpu_gnt   <= 1'b0;
            dma_gnt   <= 1'b0;
            cpu_done  <= 1'b0;
            dma_done  <= 1'b0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            mem_read  <= take && !win_we;
            mem_write <= take && win_we;
            mem_adr   <= take ? win_adr   : '0;
            mem_wdata <= take ? win_wdata : '0;
            cpu_gnt   <= take && !pick_dma;
            dma_gnt   <= take && pick_dma;
            if (take) begin
                cap_we <= win_we;
                cap_id <= pick_dma;
            end
            cpu_done  <= (state_next == DONE) && !cap_id;
            dma_done  <= (state_next == DONE) && cap_id;
            if ((state_next == DONE) && !cap_we) begin
                if (cap_id) begin
                    dma_rdata <= mem_rdata;
                end else begin
                    cpu_rdata <= mem_rdata;
                end
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances run the same stimulus with LATENCY = 1, 2 and 3.
module tb_mem_arbiter;
    localparam int W  = 8;
    localparam int NL = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_req   [NL];
    logic         cpu_we    [NL];
    logic [W-1:0] cpu_adr   [NL];
    logic [W-1:0] cpu_wdata [NL];
    logic         dma_req   [NL];
    logic         dma_we    [NL];
    logic [W-1:0] dma_adr   [NL];
    logic [W-1:0] dma_wdata [NL];
    logic         cpu_gnt   [NL];
    logic         cpu_done  [NL];
    logic [W-1:0] cpu_rdata [NL];
    logic         dma_gnt   [NL];
    logic         dma_done  [NL];
    logic [W-1:0] dma_rdata [NL];
    logic [W-1:0] mem_adr   [NL];
    logic [W-1:0] mem_wdata [NL];
    logic         mem_read  [NL];
    logic         mem_write [NL];
    logic [W-1:0] mem_rdata [NL];
    logic [1:0]   dbg_state [NL];

    logic [W-1:0] tb_mem [256];
    logic [W-1:0] exp_cpu_rdata [NL];
    logic [W-1:0] exp_dma_rdata [NL];
    int           tests_run    = 0;
    int           tests_failed = 0;

    always #5 clk = ~clk;

    // Lane g: LATENCY = g+1; memory model presents read data in the cycle before DONE, 8'hEE otherwise.
    for (genvar g = 0; g < NL; g++) begin : g_lane
        int           cd = -1;
        logic [W-1:0] dv = '0;

        mem_arbiter #(.WIDTH(W), .LATENCY(g + 1)) u_dut (
            .clk(clk), .rst(rst),
            .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_adr(cpu_adr[g]), .cpu_wdata(cpu_wdata[g]),
            .cpu_gnt(cpu_gnt[g]), .cpu_done(cpu_done[g]), .cpu_rdata(cpu_rdata[g]),
            .dma_req(dma_req[g]), .dma_we(dma_we[g]), .dma_adr(dma_adr[g]), .dma_wdata(dma_wdata[g]),
            .dma_gnt(dma_gnt[g]), .dma_done(dma_done[g]), .dma_rdata(dma_rdata[g]),
            .mem_adr(mem_adr[g]), .mem_wdata(mem_wdata[g]), .mem_read(mem_read[g]),
            .mem_write(mem_write[g]), .mem_rdata(mem_rdata[g]), .dbg_state(dbg_state[g])
        );

        always @(negedge clk) begin
            if (mem_read[g]) begin
                cd = g;
                dv = tb_mem[mem_adr[g]];
            end else if (cd >= 0) begin
                cd = cd - 1;
            end
            mem_rdata[g] = (cd == 0) ? dv : 8'hEE;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        for (int g = 0; g < NL; g++) begin
            cpu_req[g] = 1'b0; cpu_we[g] = 1'b0; cpu_adr[g] = '0; cpu_wdata[g] = '0;
            dma_req[g] = 1'b0; dma_we[g] = 1'b0; dma_adr[g] = '0; dma_wdata[g] = '0;
        end
    endtask

    task automatic test_reset();
        logic [39:0] obs;
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < NL; g++) begin
            obs = {cpu_gnt[g], dma_gnt[g], cpu_done[g], dma_done[g], mem_read[g], mem_write[g],
                   dbg_state[g], mem_adr[g], mem_wdata[g], cpu_rdata[g], dma_rdata[g]};
            tests_run++;
            if (obs !== 40'h0) begin
                tests_failed++;
                $display("FAIL reset_outputs lane%0d: got %h want %h", g, obs, 40'h0);
            end
            exp_cpu_rdata[g] = '0;
            exp_dma_rdata[g] = '0;
        end
        rst = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [37:0] obs, exp_v;
        int          l, k, ph;
        logic        dma_turn, act;
        step();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        for (int g = 0; g < NL; g++) begin
            cpu_req[g] = 1'b1; cpu_we[g] = 1'b0; cpu_adr[g] = 8'h30;
            dma_req[g] = 1'b1; dma_we[g] = 1'b0; dma_adr[g] = 8'h40;
        end
        for (int c = 1; c <= 18; c++) begin
            step();
            for (int g = 0; g < NL; g++) begin
                l  = g + 1;
                k  = (c - 1) / (l + 1);
                ph = (c - 1) % (l + 1);
                if (c >= 3 * l + 4) begin
                    cpu_req[g] = 1'b0;
                    dma_req[g] = 1'b0;
                end
`ifdef ARB_ROUND_ROBIN_EN
                dma_turn = k[0];
`else
                dma_turn = 1'b0;
`endif
                act = (k <= 3);
                if (act && ph == l) begin
                    if (dma_turn) exp_dma_rdata[g] = tb_mem[8'h40];
                    else          exp_cpu_rdata[g] = tb_mem[8'h30];
                end
                exp_v = {act && ph == 0 && !dma_turn, act && ph == 0 && dma_turn,
                         act && ph == l && !dma_turn, act && ph == l && dma_turn,
                         act && ph == 0, 1'b0,
                         (act && ph == 0) ? (dma_turn ? 8'h40 : 8'h30) : 8'h00, 8'h00,
                         exp_cpu_rdata[g], exp_dma_rdata[g]};
                obs = {cpu_gnt[g], dma_gnt[g], cpu_done[g], dma_done[g], mem_read[g], mem_write[g],
                       mem_adr[g], mem_wdata[g], cpu_rdata[g], dma_rdata[g]};
                tests_run++;
                if (obs !== exp_v) begin
                    tests_failed++;
                    $display("FAIL round_robin lane%0d c%0d: got %h want %h", g, c, obs, exp_v);
                end
            end
        end
    endtask

    task automatic test_cpu_read();
        logic [37:0] obs, exp_v;
        int          l;
        for (int g = 0; g < NL; g++) begin
            cpu_req[g] = 1'b1; cpu_we[g] = 1'b0; cpu_adr[g] = 8'h10; cpu_wdata[g] = 8'h00;
        end
        for (int c = 1; c <= 6; c++) begin
            step();
            for (int g = 0; g < NL; g++) begin
                l = g + 1;
                if (c == 2) cpu_req[g] = 1'b0;
                if (c == 1 + l) exp_cpu_rdata[g] = 8'hA5;
                exp_v = {c == 1, 1'b0, c == 1 + l, 1'b0, c == 1, 1'b0,
                         (c == 1) ? 8'h10 : 8'h00, 8'h00, exp_cpu_rdata[g], exp_dma_rdata[g]};
                obs = {cpu_gnt[g], dma_gnt[g], cpu_done[g], dma_done[g], mem_read[g], mem_write[g],
                       mem_adr[g], mem_wdata[g], cpu_rdata[g], dma_rdata[g]};
                tests_run++;
                if (obs !== exp_v) begin
                    tests_failed++;
                    $display("FAIL cpu_read lane%0d c%0d: got %h want %h", g, c, obs, exp_v);
                end
            end
        end
    endtask

    task automatic test_dma_write();
        logic [37:0] obs, exp_v;
        int          l;
        for (int g = 0; g < NL; g++) begin
            dma_req[g] = 1'b1; dma_we[g] = 1'b1; dma_adr[g] = 8'h20; dma_wdata[g] = 8'h3C;
        end
        for (int c = 1; c <= 6; c++) begin
            step();
            for (int g = 0; g < NL; g++) begin
                l = g + 1;
                if (c == 2) dma_req[g] = 1'b0;
                exp_v = {1'b0, c == 1, 1'b0, c == 1 + l, 1'b0, c == 1,
                         (c == 1) ? 8'h20 : 8'h00, (c == 1) ? 8'h3C : 8'h00,
                         exp_cpu_rdata[g], exp_dma_rdata[g]};
                obs = {cpu_gnt[g], dma_gnt[g], cpu_done[g], dma_done[g], mem_read[g], mem_write[g],
                       mem_adr[g], mem_wdata[g], cpu_rdata[g], dma_rdata[g]};
                tests_run++;
                if (obs !== exp_v) begin
                    tests_failed++;
                    $display("FAIL dma_write lane%0d c%0d: got %h want %h", g, c, obs, exp_v);
                end
            end
        end
        drive_idle();
    endtask

    task automatic test_back_to_back();
        logic [37:0] obs, exp_v;
        int          l;
        logic        s1, s2, d1, d2;
        for (int g = 0; g < NL; g++) begin
            cpu_req[g] = 1'b1; cpu_we[g] = 1'b0; cpu_adr[g] = 8'h01;
        end
        for (int c = 1; c <= 10; c++) begin
            step();
            for (int g = 0; g < NL; g++) begin
                l = g + 1;
                if (c == 1) cpu_adr[g] = 8'h02;
                if (c == 2 + l) cpu_req[g] = 1'b0;
                s1 = (c == 1);
                s2 = (c == 2 + l);
                d1 = (c == 1 + l);
                d2 = (c == 2 + 2 * l);
                if (d1) exp_cpu_rdata[g] = tb_mem[8'h01];
                if (d2) exp_cpu_rdata[g] = tb_mem[8'h02];
                exp_v = {s1 || s2, 1'b0, d1 || d2, 1'b0, s1 || s2, 1'b0,
                         s1 ? 8'h01 : (s2 ? 8'h02 : 8'h00), 8'h00, exp_cpu_rdata[g], exp_dma_rdata[g]};
                obs = {cpu_gnt[g], dma_gnt[g], cpu_done[g], dma_done[g], mem_read[g], mem_write[g],
                       mem_adr[g], mem_wdata[g], cpu_rdata[g], dma_rdata[g]};
                tests_run++;
                if (obs !== exp_v) begin
                    tests_failed++;
                    $display("FAIL back_to_back lane%0d c%0d: got %h want %h", g, c, obs, exp_v);
                end
            end
        end
    endtask

    task automatic test_req_drop();
        logic [37:0] obs, exp_v;
        int          l;
        for (int g = 0; g < NL; g++) begin
            cpu_req[g] = 1'b1; cpu_we[g] = 1'b0; cpu_adr[g] = 8'h66;
        end
        for (int c = 1; c <= 6; c++) begin
            step();
            for (int g = 0; g < NL; g++) begin
                l = g + 1;
                if (c == 1) begin
                    cpu_req[g] = 1'b0;
                    cpu_adr[g] = 8'h99;
                end
                if (c == 1 + l) exp_cpu_rdata[g] = tb_mem[8'h66];
                exp_v = {c == 1, 1'b0, c == 1 + l, 1'b0, c == 1, 1'b0,
                         (c == 1) ? 8'h66 : 8'h00, 8'h00, exp_cpu_rdata[g], exp_dma_rdata[g]};
                obs = {cpu_gnt[g], dma_gnt[g], cpu_done[g], dma_done[g], mem_read[g], mem_write[g],
                       mem_adr[g], mem_wdata[g], cpu_rdata[g], dma_rdata[g]};
                tests_run++;
                if (obs !== exp_v) begin
                    tests_failed++;
                    $display("FAIL req_drop lane%0d c%0d: got %h want %h", g, c, obs, exp_v);
                end
            end
        end
        drive_idle();
    endtask

    task automatic test_reset_mid();
        logic [39:0] obs40;
        logic [37:0] obs, exp_v;
        int          l;
        for (int g = 0; g < NL; g++) begin
            cpu_req[g] = 1'b1; cpu_we[g] = 1'b0; cpu_adr[g] = 8'h77;
        end
        step();
        for (int g = 0; g < NL; g++) begin
            tests_run++;
            if ({cpu_gnt[g], mem_read[g], mem_adr[g]} !== {1'b1, 1'b1, 8'h77}) begin
                tests_failed++;
                $display("FAIL reset_mid_strobe lane%0d: got %h want %h", g,
                         {cpu_gnt[g], mem_read[g], mem_adr[g]}, {1'b1, 1'b1, 8'h77});
            end
        end
        step();
        drive_idle();
        rst = 1'b0;
        for (int r = 0; r < 3; r++) begin
            if (r == 0) #1;
            else step();
            for (int g = 0; g < NL; g++) begin
                exp_cpu_rdata[g] = '0;
                exp_dma_rdata[g] = '0;
                obs40 = {cpu_gnt[g], dma_gnt[g], cpu_done[g], dma_done[g], mem_read[g], mem_write[g],
                         dbg_state[g], mem_adr[g], mem_wdata[g], cpu_rdata[g], dma_rdata[g]};
                tests_run++;
                if (obs40 !== 40'h0) begin
                    tests_failed++;
                    $display("FAIL reset_mid_clear lane%0d r%0d: got %h want %h", g, r, obs40, 40'h0);
                end
            end
        end
        rst = 1'b1;
        for (int g = 0; g < NL; g++) begin
            cpu_req[g] = 1'b1; cpu_we[g] = 1'b0; cpu_adr[g] = 8'h12;
        end
        for (int c = 1; c <= 5; c++) begin
            step();
            for (int g = 0; g < NL; g++) begin
                l = g + 1;
                if (c == 1) cpu_req[g] = 1'b0;
                if (c == 1 + l) exp_cpu_rdata[g] = tb_mem[8'h12];
                exp_v = {c == 1, 1'b0, c == 1 + l, 1'b0, c == 1, 1'b0,
                         (c == 1) ? 8'h12 : 8'h00, 8'h00, exp_cpu_rdata[g], exp_dma_rdata[g]};
                obs = {cpu_gnt[g], dma_gnt[g], cpu_done[g], dma_done[g], mem_read[g], mem_write[g],
                       mem_adr[g], mem_wdata[g], cpu_rdata[g], dma_rdata[g]};
                tests_run++;
                if (obs !== exp_v) begin
                    tests_failed++;
                    $display("FAIL reset_mid_after lane%0d c%0d: got %h want %h", g, c, obs, exp_v);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) tb_mem[i] = 8'(i) ^ 8'h5A;
        tb_mem[8'h10] = 8'hA5;
        rst = 1'b0;
        drive_idle();
        test_reset();
        test_round_robin();
        test_cpu_read();
        test_dma_write();
        test_back_to_back();
        test_req_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
